// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM states and the burst-length decode
// used by the burst master engine.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    // Any code outside the supported fixed-length set runs as a single beat.
    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        case (burst)
            HBURST_INCR4:  return 5'd4;
            HBURST_INCR8:  return 5'd8;
            HBURST_INCR16: return 5'd16;
            default:       return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_addr_step.sv
// Next beat address for an incrementing burst, plus a flag telling whether
// that address lands exactly on a BOUNDARY-byte line.
module ahb_addr_step #(
    parameter int ADDR_W   = 32,
    parameter int BOUNDARY = 1024
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    output logic [ADDR_W-1:0] next_addr,
    output logic              bound_hit
);

    localparam int BW = $clog2(BOUNDARY);

    assign next_addr = addr + (ADDR_W'(1) << size);
    assign bound_hit = (next_addr[BW-1:0] == '0);

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one queued command becomes a pipelined burst with
// wait-state stalls, BUSY insertion for late write data, 1KB split and ERROR abort.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BOUNDARY = 1024
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic              hreadyin,
    input  logic              hreadyout,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    localparam logic [2:0] SIZE_MAX = (DATA_W >= 64) ? HSIZE_DWORD :
                                      (DATA_W == 32) ? HSIZE_WORD  :
                                      (DATA_W == 16) ? HSIZE_HALF  : HSIZE_BYTE;

    function automatic logic [2:0] sat_size(input logic [2:0] size);
        return (size > SIZE_MAX) ? SIZE_MAX : size;
    endfunction

    function automatic logic [2:0] legal_burst(input logic [2:0] burst);
        return (beats_of(burst) == 5'd1) ? HBURST_SINGLE : burst;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_d;
    logic              hwrite_d;
    logic [2:0]        hsize_d, hburst_d;
    logic [DATA_W-1:0] hwdata_d, rd_data_d;
    logic [4:0]        addr_left_q, addr_left_d;
    logic              first_q, first_d;
    logic              vld_p1, vld_p1_d, last_p1, last_p1_d, write_p1, write_p1_d;
    logic              err_q, err_d;
    logic              rd_valid_d, rd_last_d, done_d, err_out_d;
    logic [ADDR_W-1:0] next_addr;
    logic              bound_hit;
    logic              addr_act, addr_done, err_first;

    ahb_addr_step #(.ADDR_W(ADDR_W), .BOUNDARY(BOUNDARY)) u_step (
        .addr      (haddr),
        .size      (hsize),
        .next_addr (next_addr),
        .bound_hit (bound_hit)
    );

    assign hreadyin  = 1'b1;
    assign cmd_ready = (state_q == ST_IDLE);
    assign addr_act  = (htrans_q == HTRANS_NONSEQ) || (htrans_q == HTRANS_SEQ);
    // First ERROR cycle: withdraw the overlapping address phase immediately.
    assign err_first = vld_p1 && hresp && !hreadyout;

    always_comb begin
        htrans = htrans_q;
        if (err_first)
            htrans = HTRANS_IDLE;
        else if (hwrite && addr_act && !wr_valid)
            htrans = first_q ? HTRANS_IDLE : HTRANS_BUSY;
    end

    assign addr_done = hreadyout && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign wr_pop    = addr_done && hwrite && !hreset;

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr;
        hwrite_d    = hwrite;
        hsize_d     = hsize;
        hburst_d    = hburst;
        hwdata_d    = hwdata;
        addr_left_d = addr_left_q;
        first_d     = first_q;
        vld_p1_d    = vld_p1;
        last_p1_d   = last_p1;
        write_p1_d  = write_p1;
        err_d       = err_q;
        rd_data_d   = rd_data;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        done_d      = 1'b0;
        err_out_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    haddr_d     = cmd_addr;
                    hwrite_d    = cmd_write;
                    hsize_d     = sat_size(cmd_size);
                    hburst_d    = legal_burst(cmd_burst);
                    addr_left_d = beats_of(cmd_burst);
                    htrans_d    = HTRANS_NONSEQ;
                    first_d     = 1'b1;
                    err_d       = 1'b0;
                    state_d     = ST_ADDR;
                end
            end
            default: begin
                if (hreadyout) begin
                    // p1: data phase of the previously accepted beat
                    if (vld_p1) begin
                        vld_p1_d = 1'b0;
                        err_d    = err_q | hresp;
                        if (!write_p1 && !hresp) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = hrdata;
                            rd_last_d  = last_p1;
                        end
                        if (last_p1) begin
                            done_d    = 1'b1;
                            err_out_d = err_q | hresp;
                            state_d   = ST_IDLE;
                        end
                    end
                    // p0: address phase of the next beat
                    if (addr_done) begin
                        vld_p1_d    = 1'b1;
                        write_p1_d  = hwrite;
                        last_p1_d   = (addr_left_q == 5'd1);
                        addr_left_d = addr_left_q - 5'd1;
                        haddr_d     = next_addr;
                        first_d     = 1'b0;
                        if (hwrite)
                            hwdata_d = wr_data;
                        if (addr_left_q == 5'd1) begin
                            htrans_d = HTRANS_IDLE;
                            state_d  = ST_LAST;
                        end else if (bound_hit) begin
                            htrans_d = HTRANS_NONSEQ;
                            hburst_d = HBURST_INCR;
                        end else begin
                            htrans_d = HTRANS_SEQ;
                        end
                    end
                end else if (err_first) begin
                    htrans_d    = HTRANS_IDLE;
                    addr_left_d = 5'd0;
                    last_p1_d   = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_LAST;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hsize       <= '0;
            hburst      <= '0;
            hwdata      <= '0;
            addr_left_q <= '0;
            first_q     <= 1'b0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            write_p1    <= 1'b0;
            err_q       <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr       <= haddr_d;
            hwrite      <= hwrite_d;
            hsize       <= hsize_d;
            hburst      <= hburst_d;
            hwdata      <= hwdata_d;
            addr_left_q <= addr_left_d;
            first_q     <= first_d;
            vld_p1      <= vld_p1_d;
            last_p1     <= last_p1_d;
            write_p1    <= write_p1_d;
            err_q       <= err_d;
            rd_data     <= rd_data_d;
            rd_valid    <= rd_valid_d;
            rd_last     <= rd_last_d;
            done        <= done_d;
            err         <= err_out_d;
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: the bench plays the AHB slave cycle by
// cycle and checks bus and command-side outputs against hand-computed values.
module tb_ahb_burst_master;
    import ahb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              hclk = 1'b0;
    logic              hreset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_burst, cmd_size;
    logic [DATA_W-1:0] wr_data, rd_data, hwdata, hrdata;
    logic              wr_valid, wr_pop, rd_valid, rd_last, done, err;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite, hreadyin, hreadyout, hresp;
    logic [2:0]        hsize, hburst;
    logic [1:0]        htrans;

    int n_assert = 0;
    int n_fail   = 0;
    int pop_cnt = 0, rdv_cnt = 0, rdl_cnt = 0, done_cnt = 0;
    int base_pop, base_rdv, base_rdl, base_done;

    ahb_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOUNDARY(1024)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_size  (cmd_size),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_pop    (wr_pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done),
        .err       (err),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .htrans    (htrans),
        .hreadyin  (hreadyin),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    always #5 hclk = ~hclk;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge hclk) begin
        if (wr_pop)   pop_cnt  <= pop_cnt + 1;
        if (rd_valid) rdv_cnt  <= rdv_cnt + 1;
        if (rd_last)  rdl_cnt  <= rdl_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic snap();
        base_pop  = pop_cnt;
        base_rdv  = rdv_cnt;
        base_rdl  = rdl_cnt;
        base_done = done_cnt;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wword(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_burst = '0; cmd_size = '0; wr_data = '0; wr_valid = 1'b0;
        hreadyout = 1'b1; hresp = 1'b0; hrdata = '0;
        tick(); tick();
        chk("rst_htrans", htrans, HTRANS_IDLE);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_hreadyin", hreadyin, 1);
        hreset = 1'b0;
        tick();

        // SINGLE write, byte size
        snap();
        wr_data = 32'h24; wr_valid = 1'b1;
        issue(1'b1, 32'h8000_0000, HBURST_SINGLE, HSIZE_BYTE);
        chk("t1_htrans", htrans, HTRANS_NONSEQ);
        chk("t1_haddr", haddr, 32'h8000_0000);
        chk("t1_hwrite", hwrite, 1);
        chk("t1_hburst", hburst, HBURST_SINGLE);
        chk("t1_cmd_ready", cmd_ready, 0);
        chk("t1_wr_pop", wr_pop, 1);
        tick();
        wr_valid = 1'b0; #1;
        chk("t1_hwdata", hwdata, 32'h24);
        chk("t1_htrans_end", htrans, HTRANS_IDLE);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_pops", pop_cnt - base_pop, 1);

        // INCR4 read with two wait states on beat 2
        snap();
        issue(1'b0, 32'h8000_0000, HBURST_INCR4, HSIZE_WORD);
        chk("t2_htrans0", htrans, HTRANS_NONSEQ);
        chk("t2_hburst", hburst, HBURST_INCR4);
        tick(); hrdata = 32'hA1;
        chk("t2_haddr1", haddr, 32'h8000_0004);
        chk("t2_htrans1", htrans, HTRANS_SEQ);
        tick();
        chk("t2_rd1", rd_data, 32'hA1);
        chk("t2_rdv1", rd_valid, 1);
        chk("t2_haddr2", haddr, 32'h8000_0008);
        hreadyout = 1'b0;
        tick();
        chk("t2_wait_haddr", haddr, 32'h8000_0008);
        chk("t2_wait_rdv", rd_valid, 0);
        tick();
        chk("t2_wait2_haddr", haddr, 32'h8000_0008);
        chk("t2_wait2_htrans", htrans, HTRANS_SEQ);
        hreadyout = 1'b1; hrdata = 32'hA2;
        tick(); hrdata = 32'hA3;
        chk("t2_rd2", rd_data, 32'hA2);
        chk("t2_haddr3", haddr, 32'h8000_000C);
        tick(); hrdata = 32'hA4;
        chk("t2_rd3", rd_data, 32'hA3);
        chk("t2_last3", rd_last, 0);
        chk("t2_htrans_end", htrans, HTRANS_IDLE);
        tick();
        chk("t2_rd4", rd_data, 32'hA4);
        chk("t2_last4", rd_last, 1);
        chk("t2_done", done, 1);
        tick();
        chk("t2_rdv_count", rdv_cnt - base_rdv, 4);
        chk("t2_rdl_count", rdl_cnt - base_rdl, 1);

        // INCR8 write, write data stalls for two cycles after beat 3
        snap();
        wr_valid = 1'b1; wr_data = wword(1);
        issue(1'b1, 32'h0000_0100, HBURST_INCR8, HSIZE_WORD);
        for (int k = 1; k <= 3; k++) begin
            wr_data = wword(k);
            tick();
            chk("t3_hwdata", hwdata, wword(k));
        end
        wr_valid = 1'b0; #1;
        chk("t3_busy1", htrans, HTRANS_BUSY);
        chk("t3_busy1_haddr", haddr, 32'h10C);
        chk("t3_busy1_pop", wr_pop, 0);
        tick();
        chk("t3_busy2", htrans, HTRANS_BUSY);
        chk("t3_busy2_haddr", haddr, 32'h10C);
        chk("t3_busy2_hwdata", hwdata, wword(3));
        tick();
        wr_valid = 1'b1; #1;
        chk("t3_resume", htrans, HTRANS_SEQ);
        chk("t3_resume_haddr", haddr, 32'h10C);
        for (int k = 4; k <= 8; k++) begin
            wr_data = wword(k);
            tick();
            chk("t3_hwdata", hwdata, wword(k));
        end
        chk("t3_htrans_end", htrans, HTRANS_IDLE);
        wr_valid = 1'b0;
        tick();
        chk("t3_done", done, 1);
        tick();
        chk("t3_pops", pop_cnt - base_pop, 8);

        // INCR16 read crossing the 1KB line at beat 5
        snap();
        hrdata = 32'h5A5A;
        issue(1'b0, 32'h0000_03F0, HBURST_INCR16, HSIZE_WORD);
        chk("t4_haddr1", haddr, 32'h3F0);
        chk("t4_hburst1", hburst, HBURST_INCR16);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk("t4_haddr", haddr, 32'h3F0 + 32'(4 * (k - 1)));
            chk("t4_htrans", htrans, (k == 5) ? HTRANS_NONSEQ : HTRANS_SEQ);
            chk("t4_hburst", hburst, (k >= 5) ? HBURST_INCR : HBURST_INCR16);
        end
        tick();
        chk("t4_htrans_end", htrans, HTRANS_IDLE);
        tick();
        chk("t4_done", done, 1);
        chk("t4_err", err, 0);
        tick();
        chk("t4_rdv_count", rdv_cnt - base_rdv, 16);
        chk("t4_rdl_count", rdl_cnt - base_rdl, 1);

        // INCR8 read aborted by ERROR on beat 3
        snap();
        issue(1'b0, 32'h0000_0200, HBURST_INCR8, HSIZE_WORD);
        tick(); hrdata = 32'hB1;
        tick(); hrdata = 32'hB2;
        chk("t5_rd1", rd_data, 32'hB1);
        tick();
        chk("t5_rd2", rd_data, 32'hB2);
        chk("t5_haddr", haddr, 32'h20C);
        hresp = 1'b1; hreadyout = 1'b0; #1;
        chk("t5_err1_htrans", htrans, HTRANS_IDLE);
        tick();
        chk("t5_err2_htrans", htrans, HTRANS_IDLE);
        chk("t5_err2_done", done, 0);
        hreadyout = 1'b1;
        tick();
        hresp = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        chk("t5_rdv", rd_valid, 0);
        tick();
        chk("t5_done_pulse", done, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_rdv_count", rdv_cnt - base_rdv, 2);

        // Reset in the middle of an INCR4 write
        snap();
        wr_valid = 1'b1; wr_data = 32'h66;
        issue(1'b1, 32'h0000_0300, HBURST_INCR4, HSIZE_WORD);
        tick(); tick();
        hreset = 1'b1;
        tick();
        chk("t6_htrans", htrans, HTRANS_IDLE);
        chk("t6_haddr", haddr, 0);
        chk("t6_hwdata", hwdata, 0);
        chk("t6_hwrite", hwrite, 0);
        chk("t6_hburst", hburst, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_wr_pop", wr_pop, 0);
        hreset = 1'b0; wr_valid = 1'b0;
        tick(); tick(); tick();
        chk("t6_no_done", done_cnt - base_done, 0);
        chk("t6_pops", pop_cnt - base_pop, 2);
        chk("t6_idle", htrans, HTRANS_IDLE);

        // Oversized HSIZE clamps, unsupported HBURST runs as SINGLE
        issue(1'b0, 32'h0000_0040, 3'b010, HSIZE_DWORD);
        chk("t7_hsize", hsize, HSIZE_WORD);
        chk("t7_hburst", hburst, HBURST_SINGLE);
        chk("t7_htrans", htrans, HTRANS_NONSEQ);
        tick();
        chk("t7_htrans_end", htrans, HTRANS_IDLE);
        tick();
        chk("t7_done", done, 1);

        // First write beat held as IDLE until write data arrives
        tick();
        issue(1'b1, 32'h0000_0080, HBURST_SINGLE, HSIZE_WORD);
        chk("t8_wait_htrans", htrans, HTRANS_IDLE);
        chk("t8_wait_haddr", haddr, 32'h80);
        chk("t8_cmd_ready", cmd_ready, 0);
        tick();
        chk("t8_wait2_htrans", htrans, HTRANS_IDLE);
        wr_valid = 1'b1; wr_data = 32'h77; #1;
        chk("t8_htrans", htrans, HTRANS_NONSEQ);
        chk("t8_wr_pop", wr_pop, 1);
        tick();
        wr_valid = 1'b0;
        chk("t8_hwdata", hwdata, 32'h77);
        tick();
        chk("t8_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
